// File: rtl/step_run_controller.sv
// Run / single-step controller producing a clock enable for the CPU.
// Ports: CLK, CLR (sync reset), G (run mode), STEP_BTN (raw button),
//        HALT_TAG (CPU halt) -> CPU_EN, RUNNING, HALTED, CYCLE_CNT.
module step_run_controller #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             G,
   input  logic             STEP_BTN,
   input  logic             HALT_TAG,
   output logic             CPU_EN,
   output logic             RUNNING,
   output logic             HALTED,
   output logic [CNT_W-1:0] CYCLE_CNT
);

   localparam int DW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   state_t        state;
   logic          s1;
   logic          s2;
   logic          db;
   logic          db_q;
   logic [DW-1:0] db_cnt;
   logic          en_q;
   logic          step_pulse;

   assign step_pulse = db & ~db_q;
   // Halt masks the enable in the same cycle it appears.
   assign CPU_EN     = en_q & ~HALT_TAG;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         db     <= 1'b0;
         db_q   <= 1'b0;
         db_cnt <= '0;
      end else begin
         s1   <= STEP_BTN;
         s2   <= s1;
         db_q <= db;
         if (s2 != db) begin
            if (db_cnt == DB_LAST) begin
               db     <= s2;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + 1'b1;
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         CYCLE_CNT <= '0;
      end else if (CPU_EN && CYCLE_CNT != CNT_MAX) begin
         CYCLE_CNT <= CYCLE_CNT + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= IDLE;
         en_q    <= 1'b0;
         RUNNING <= 1'b0;
         HALTED  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (HALT_TAG) begin
                  state  <= HALT;
                  en_q   <= 1'b0;
                  HALTED <= 1'b1;
               end else if (G) begin
                  // A coincident step is absorbed by the run.
                  state   <= RUN;
                  en_q    <= 1'b1;
                  RUNNING <= 1'b1;
               end else begin
                  en_q <= step_pulse;
               end
            end
            RUN: begin
               if (HALT_TAG) begin
                  state   <= HALT;
                  en_q    <= 1'b0;
                  RUNNING <= 1'b0;
                  HALTED  <= 1'b1;
               end else if (!G) begin
                  state   <= IDLE;
                  en_q    <= 1'b0;
                  RUNNING <= 1'b0;
               end else begin
                  en_q <= 1'b1;
               end
            end
            HALT: begin
               en_q <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               en_q    <= 1'b0;
               RUNNING <= 1'b0;
               HALTED  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_run_controller.sv
// Bench for step_run_controller: directed phases plus random stimulus
// checked every cycle against a behavioural model.
module tb_step_run_controller;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        g = 1'b0;
   logic        step_btn = 1'b0;
   logic        halt_tag = 1'b0;
   logic        cpu_en16;
   logic        running16;
   logic        halted16;
   logic [15:0] cnt16;
   logic        cpu_en4;
   logic        running4;
   logic        halted4;
   logic [3:0]  cnt4;

   int n_cmp = 0;
   int n_bad = 0;

   step_run_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut16 (
      .CLK(clk), .CLR(clr), .G(g), .STEP_BTN(step_btn),
      .HALT_TAG(halt_tag), .CPU_EN(cpu_en16), .RUNNING(running16),
      .HALTED(halted16), .CYCLE_CNT(cnt16)
   );

   step_run_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut4 (
      .CLK(clk), .CLR(clr), .G(g), .STEP_BTN(step_btn),
      .HALT_TAG(halt_tag), .CPU_EN(cpu_en4), .RUNNING(running4),
      .HALTED(halted4), .CYCLE_CNT(cnt4)
   );

   always #5 clk = ~clk;

   task automatic check(string name, longint act, longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Behavioural model: the button is seen two edges late, the
   // debounced level flips after D consecutive differing samples,
   // and the CPU is enabled by run mode or by one debounced press.
   typedef enum {M_IDLE, M_RUN, M_HALT} mode_t;
   mode_t       m_mode = M_IDLE;
   bit          m_en = 0;
   longint      m_cnt = 0;
   bit          m_db = 0;
   bit          m_dbq = 0;
   bit          m_dly0 = 0;
   bit          m_dly1 = 0;
   bit          m_win[$];
   bit          m_pulse;
   bit          m_flip;
   bit          started = 0;

   always @(posedge clk) begin
      if (clr) begin
         m_mode = M_IDLE;
         m_en   = 0;
         m_cnt  = 0;
         m_db   = 0;
         m_dbq  = 0;
         m_dly0 = 0;
         m_dly1 = 0;
         m_win.delete();
      end else begin
         if (m_en && !halt_tag) m_cnt++;
         m_pulse = m_db && !m_dbq;
         case (m_mode)
            M_IDLE:
               if (halt_tag) begin
                  m_mode = M_HALT; m_en = 0;
               end else if (g) begin
                  m_mode = M_RUN; m_en = 1;
               end else begin
                  m_en = m_pulse;
               end
            M_RUN:
               if (halt_tag) begin
                  m_mode = M_HALT; m_en = 0;
               end else if (!g) begin
                  m_mode = M_IDLE; m_en = 0;
               end else begin
                  m_en = 1;
               end
            default: m_en = 0;
         endcase
         m_dbq = m_db;
         m_win.push_back(m_dly1);
         if (m_win.size() > D) void'(m_win.pop_front());
         m_flip = (m_win.size() == D);
         foreach (m_win[i]) if (m_win[i] == m_db) m_flip = 0;
         if (m_flip) begin
            m_db = !m_db;
            m_win.delete();
         end
         m_dly1 = m_dly0;
         m_dly0 = step_btn;
      end
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         check("cpu_en", cpu_en16, m_en && !halt_tag);
         check("running", running16, m_mode == M_RUN);
         check("halted", halted16, m_mode == M_HALT);
         check("cnt16", cnt16, (m_cnt > 65535) ? 65535 : m_cnt);
         check("cnt4", cnt4, (m_cnt > 15) ? 15 : m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   int first;
   int highs;
   bit lvl;

   initial begin
      // Reset held with G and button asserted.
      clr = 1'b1; g = 1'b1; step_btn = 1'b1;
      repeat (2) begin
         tick();
         check("rst_en", cpu_en16, 0);
         check("rst_run", running16, 0);
         check("rst_halt", halted16, 0);
         check("rst_cnt", cnt16, 0);
      end
      clr = 1'b0; g = 1'b0; step_btn = 1'b0;
      repeat (4) tick();

      // Clean single step, then a second press.
      do_reset();
      step_btn = 1'b1;
      first = -1; highs = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (cpu_en16) begin
            highs++;
            if (first < 0) first = k;
         end
      end
      check("step_lat", first, D + 2);
      check("step_once", highs, 1);
      step_btn = 1'b0;
      repeat (12) tick();
      check("step_cnt1", cnt16, 1);
      step_btn = 1'b1;
      repeat (20) tick();
      step_btn = 1'b0;
      repeat (12) tick();
      check("step_cnt2", cnt16, 2);

      // Bounce shorter than the debounce window.
      do_reset();
      highs = 0;
      for (int k = 0; k < 16; k++) begin
         step_btn = (k == 0 || k == 2);
         tick();
         highs += int'(cpu_en16);
      end
      check("bounce_en", highs, 0);
      check("bounce_cnt", cnt16, 0);

      // Run for ten cycles with a step press held inside the run.
      do_reset();
      g = 1'b1; highs = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 0) step_btn = 1'b1;
         if (k == 6) step_btn = 1'b0;
         tick();
         highs += int'(cpu_en16);
      end
      g = 1'b0;
      tick();
      highs += int'(cpu_en16);
      repeat (12) tick();
      check("run_highs", highs, 10);
      check("run_cnt", cnt16, 10);
      check("run_idle", running16, 0);

      // Halt in the middle of a run.
      do_reset();
      g = 1'b1;
      repeat (6) tick();
      check("pre_halt_cnt", cnt16, 5);
      halt_tag = 1'b1;
      #1;
      check("halt_mask", cpu_en16, 0);
      tick();
      check("halt_flag", halted16, 1);
      for (int k = 0; k < 20; k++) begin
         g = k[2];
         step_btn = (k >= 3 && k <= 14);
         if (k == 10) halt_tag = 1'b0;
         tick();
      end
      check("halt_cnt", cnt16, 5);
      check("halt_sticky", halted16, 1);
      g = 1'b0; step_btn = 1'b0;
      do_reset();
      check("halt_clr", halted16, 0);
      check("halt_clr_run", running16, 0);

      // Saturation of the narrow counter.
      do_reset();
      g = 1'b1;
      repeat (20) tick();
      check("sat_cnt4", cnt4, 15);
      check("sat_cnt16", cnt16, 19);
      repeat (5) tick();
      check("sat_hold", cnt4, 15);
      g = 1'b0;
      tick();

      // Random stimulus against the model.
      lvl = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         clr = ($urandom_range(0, 199) == 0) ||
               (m_mode == M_HALT && $urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) g = ~g;
         if (halt_tag) begin
            if ($urandom_range(0, 9) == 0) halt_tag = 1'b0;
         end else if ($urandom_range(0, 299) == 0) begin
            halt_tag = 1'b1;
         end
         if ($urandom_range(0, 24) == 0) lvl = ~lvl;
         step_btn = lvl ^ ($urandom_range(0, 14) == 0);
         tick();
      end
      clr = 1'b0;
      tick();
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
